// File: rtl/sub_nibble_serial_pkg.sv
// Shared constants for the nibble-serial subtractor: FSM encoding, the nibble
// width, and the helper that sizes the nibble counter.
package sub_nibble_serial_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter width that can hold nibble indices 0..nibbles-1.
    function automatic int unsigned cnt_width(input int unsigned nibbles);
        return (nibbles < 2) ? 1 : $clog2(nibbles);
    endfunction

    localparam int unsigned NIBBLES_DEF = 4;
    localparam int unsigned CNT_W_DEF   = cnt_width(NIBBLES_DEF);

endpackage

// File: rtl/sub_nibble_stage.sv
// One 4-bit subtract-with-borrow stage: {out_Bout, out_D} = in_A - in_B - in_Bin.
// Ports:
//   in_A, in_B  4-bit operands
//   in_Bin      borrow in
//   out_D       4-bit difference
//   out_Bout    borrow out, 1 iff in_A < in_B + in_Bin
module sub_nibble_stage
    import sub_nibble_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] in_A,
    input  logic [NIBBLE_W-1:0] in_B,
    input  logic                in_Bin,
    output logic [NIBBLE_W-1:0] out_D,
    output logic                out_Bout
);

    // One extra bit so the wrap into the MSB is exactly the borrow.
    logic [NIBBLE_W:0] diff_c;

    assign diff_c   = {1'b0, in_A} - {1'b0, in_B} - (NIBBLE_W+1)'(in_Bin);
    assign out_D    = diff_c[NIBBLE_W-1:0];
    assign out_Bout = diff_c[NIBBLE_W];

endmodule

// File: rtl/sub_nibble_serial.sv
// Wide subtractor D = A - B - Bin computed one nibble per cycle, LSB first,
// through a single shared nibble stage. start/busy/done handshake; the result
// is held until the next accepted start.
// Ports:
//   in_clk, in_rst     clock, async active-high reset
//   in_start           request, honoured only in IDLE or DONE
//   in_A, in_B, in_Bin operands, captured on the accepting edge
//   out_busy           high while nibbles are being processed
//   out_done           one-cycle completion pulse
//   out_D              difference mod 2^W (partial while busy)
//   out_Bout           final borrow
//   out_zero           out_D == 0
module sub_nibble_serial
    import sub_nibble_serial_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic                      in_start,
    input  logic [NIBBLES*NIBBLE_W-1:0] in_A,
    input  logic [NIBBLES*NIBBLE_W-1:0] in_B,
    input  logic                      in_Bin,
    output logic                      out_busy,
    output logic                      out_done,
    output logic [NIBBLES*NIBBLE_W-1:0] out_D,
    output logic                      out_Bout,
    output logic                      out_zero
);

    localparam int unsigned W     = NIBBLES * NIBBLE_W;
    localparam int unsigned CNT_W = cnt_width(NIBBLES);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [W-1:0]        a_sh;
    logic [W-1:0]        b_sh;
    logic                borrow;
    logic [CNT_W-1:0]    cnt;

    logic                accept_c;
    logic                last_c;
    logic [NIBBLE_W-1:0] stage_d_c;
    logic                stage_bout_c;
    logic [W-1:0]        d_next_c;

    assign accept_c = in_start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_c   = (cnt == CNT_W'(NIBBLES - 1));
    // New nibble enters at the MSB end; after NIBBLES shifts it is in place.
    assign d_next_c = {stage_d_c, out_D[W-1:NIBBLE_W]};

    sub_nibble_stage u_stage (
        .in_A     (a_sh[NIBBLE_W-1:0]),
        .in_B     (b_sh[NIBBLE_W-1:0]),
        .in_Bin   (borrow),
        .out_D    (stage_d_c),
        .out_Bout (stage_bout_c)
    );

    // State register.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_start) state_nxt = ST_RUN;
            ST_RUN:  if (last_c)   state_nxt = ST_DONE;
            ST_DONE: state_nxt = in_start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status flags registered from the next state so they track state exactly.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_busy <= 1'b0;
            out_done <= 1'b0;
        end else begin
            out_busy <= (state_nxt == ST_RUN);
            out_done <= (state_nxt == ST_DONE);
        end
    end

    // Operand shifters, borrow chain, counter and result register.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            out_D    <= '0;
            out_Bout <= 1'b0;
            out_zero <= 1'b0;
        end else if (accept_c) begin
            a_sh     <= in_A;
            b_sh     <= in_B;
            borrow   <= in_Bin;
            cnt      <= '0;
            out_D    <= '0;
            out_Bout <= 1'b0;
            out_zero <= 1'b0;
        end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> NIBBLE_W;
            b_sh   <= b_sh >> NIBBLE_W;
            borrow <= stage_bout_c;
            cnt    <= cnt + CNT_W'(1);
            out_D  <= d_next_c;
            // Flags are published together with the final nibble.
            if (last_c) begin
                out_Bout <= stage_bout_c;
                out_zero <= (d_next_c == '0);
            end
        end
    end

endmodule

// File: doc/sub_nibble_serial.md
Name: sub_nibble_serial

Overview:
- Multi-cycle controller that performs wide subtraction D = A - B - Bin by sequencing one 4-bit subtract-with-borrow stage over successive nibbles, LSB first.
- Sits between a requester and the 4-bit subtractor datapath. Wide operands share one nibble stage instead of a ripple chain of N stages.
- Uses a start/busy/done handshake. The result is held until the next accepted start.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..16

Ports:
in_clk  input  1  clock, rising edge
in_rst  input  1  asynchronous, active-high reset
in_start  input  1  request; sampled only in IDLE or DONE
in_A  input  W  minuend, captured on accepted start
in_B  input  W  subtrahend, captured on accepted start
in_Bin  input  1  initial borrow-in, captured on accepted start
out_busy  output  1  high in RUN
out_done  output  1  one-cycle pulse in DONE
out_D  output  W  difference, (A - B - Bin) mod 2^W
out_Bout  output  1  final borrow; 1 iff A < B + Bin (unsigned)
out_zero  output  1  1 iff out_D == 0

Behaviour:
- Reset (async, any state): state=IDLE; out_busy=0, out_done=0, out_D=0, out_Bout=0, out_zero=0; internal registers and nibble counter cleared. A reset asserted mid-RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- Start acceptance: start is accepted when in_start=1 at a rising edge while in IDLE or DONE.
  - Capture A and B into shift registers, and Bin into the borrow register.
  - Clear nibble counter and out_D.
  - Go to RUN.
- RUN, each cycle:
  - The nibble stage receives A[3:0], B[3:0] and the borrow register.
  - It produces {bout, d} = A_nib - B_nib - borrow. d is 4 bits; bout = 1 iff A_nib < B_nib + borrow.
  - d shifts into out_D from the MSB end; out_D is right-shifted 4 per cycle.
  - A and B shift right 4. Borrow register <= bout. Counter increments.
  - When counter == NIBBLES-1, go to DONE. RUN lasts exactly NIBBLES cycles.
- DONE:
  - out_done=1 for one cycle.
  - out_Bout = last borrow. out_zero is valid.
  - Next state: RUN if in_start=1 (back-to-back), else IDLE.
- Latency: start sampled at edge t; out_done high in cycle t+NIBBLES+1. Throughput is one operation per NIBBLES+1 cycles.
- Start while busy: ignored, with no effect on the operation in progress. in_A, in_B and in_Bin are don't-care outside the acceptance edge.
- Output hold:
  - out_D, out_Bout and out_zero hold their final values through DONE and IDLE until the next accepted start.
  - On an accepted start, out_Bout and out_zero clear to 0.
  - out_D is a partial value during RUN and must not be used.
- out_busy = (state==RUN). out_done = (state==DONE). Both are registered and glitch-free.
- Wrap-around: differences are modulo 2^W. Negative results appear in two's complement with out_Bout=1.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - NIBBLE_W=4;
  - a counter-width constant derived from NIBBLES (clog2).
- One combinational sub-module, sub_nibble_stage:
  - ports in_A[3:0], in_B[3:0], in_Bin, out_D[3:0], out_Bout;
  - function {out_Bout,out_D} = in_A - in_B - in_Bin.
- The controller owns the FSM, counter, shift registers and result register.

Test Plan (NIBBLES=4):
1. Basic subtract: A=0x1234, B=0x0234, Bin=0, start one cycle -> out_busy high 4 cycles, then done pulse. out_D=0x1000, out_Bout=0, out_zero=0.
2. Negative result: A=0x0005, B=0x0007, Bin=0 -> out_D=0xFFFE, out_Bout=1. Also A=0x0000, B=0x0001 -> out_D=0xFFFF, out_Bout=1, with the borrow rippling through all 4 nibbles.
3. Zero and borrow-in:
   - A=0x8000, B=0x8000, Bin=0 -> out_D=0x0000, out_zero=1, out_Bout=0.
   - A=0x0010, B=0x0000, Bin=1 -> out_D=0x000F, out_Bout=0.
   - A=0, B=0, Bin=1 -> out_D=0xFFFF, out_Bout=1.
4. Handshake:
   - in_start pulsed during RUN with different operands -> ignored; the first result is delivered unchanged.
   - in_start held high in DONE -> new operation starts with no IDLE cycle; the second done arrives NIBBLES+1 cycles after the first.
5. Reset mid-operation: assert in_rst at RUN cycle 2 -> all outputs 0 immediately (async), no done pulse. After release, a new start completes correctly: 0x00FF-0x0001=0x00FE.
6. Result hold: after done, idle 20 cycles with operand inputs toggling -> out_D, out_Bout and out_zero remain stable.
